// File: rtl/mult_err_monitor_pkg.sv
// Shared types for the multiplier error monitor.
// Operand width default and FSM state encodings.
package mult_err_monitor_pkg;

  localparam int OP_W_DEF = 8;
  localparam int P_W_DEF  = 2 * OP_W_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mult_err_monitor_if.sv
// Sample stream (a, b, y) with valid/ready handshake.
// master drives valid/a/b/y; slave drives ready.
interface mult_err_monitor_if
  import mult_err_monitor_pkg::*;
#(
  parameter int OP_W = OP_W_DEF
) ();

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_a;
  logic [OP_W-1:0]   in_b;
  logic [2*OP_W-1:0] in_y;

  modport master (
    output in_valid, in_a, in_b, in_y,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_a, in_b, in_y,
    output in_ready
  );

endinterface

// File: rtl/mult_err_monitor_exact_mult_ref.sv
// exact_mult_ref: combinational unsigned OP_W x OP_W multiplier.
// Ports: a, b (OP_W) in; p (2*OP_W) out.
module exact_mult_ref
  import mult_err_monitor_pkg::*;
#(
  parameter int OP_W = OP_W_DEF
) (
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [2*OP_W-1:0] p
);

  logic [2*OP_W-1:0] a_x;
  logic [2*OP_W-1:0] b_x;

  assign a_x = {{OP_W{1'b0}}, a};
  assign b_x = {{OP_W{1'b0}}, b};
  assign p   = a_x * b_x;

endmodule

// File: rtl/mult_err_monitor.sv
// Streaming checker: recomputes a*b, accumulates sample/error counts,
// ED sum (saturating) and, with ERR_MAX_TRACK_EN defined, max ED.
// Ports: clk, rst_n, start, bus (slave: in_valid/in_ready/in_a/in_b/in_y),
// busy, done, sample_cnt, err_cnt, ed_sum, ed_max.
module mult_err_monitor
  import mult_err_monitor_pkg::*;
#(
  parameter int OP_W      = OP_W_DEF,
  parameter int N_SAMPLES = 65536,
  parameter int CNT_W     = 17,
  parameter int ACC_W     = 40
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  mult_err_monitor_if.slave  bus,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [ACC_W-1:0]   ed_sum,
  output logic [2*OP_W-1:0]  ed_max
);

  localparam int P_W = 2 * OP_W;
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_SAMPLES - 1);

  state_t           state;
  logic [CNT_W-1:0] acc_cnt;
  logic             drain_cnt;
  logic             ready_q;
  logic             accept;
  logic             start_ok;

  logic             s1_v;
  logic [OP_W-1:0]  s1_a;
  logic [OP_W-1:0]  s1_b;
  logic [P_W-1:0]   s1_y;
  logic             s2_v;
  logic [P_W-1:0]   s2_ed;
  logic             s2_err;

  logic [P_W-1:0]   exact;
  logic [P_W-1:0]   ed_c;
  logic [ACC_W:0]   sum_c;

  assign bus.in_ready = ready_q;
  assign accept   = bus.in_valid & ready_q;
  assign start_ok = start & ((state == IDLE) | (state == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc_cnt   <= '0;
      drain_cnt <= 1'b0;
      ready_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= RUN;
            acc_cnt <= '0;
            ready_q <= 1'b1;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
            if (acc_cnt == N_LAST) begin
              ready_q   <= 1'b0;
              drain_cnt <= 1'b0;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // two cycles lets the last sample clear S1 and S2
          if (drain_cnt) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  exact_mult_ref #(.OP_W(OP_W)) u_ref (
    .a (s1_a),
    .b (s1_b),
    .p (exact)
  );

  assign ed_c  = (exact >= s1_y) ? (exact - s1_y) : (s1_y - exact);
  assign sum_c = {1'b0, ed_sum} + (ACC_W+1)'(s2_ed);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v       <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_y       <= '0;
      s2_v       <= 1'b0;
      s2_ed      <= '0;
      s2_err     <= 1'b0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
    end else if (start_ok) begin
      s1_v       <= 1'b0;
      s2_v       <= 1'b0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_a <= bus.in_a;
        s1_b <= bus.in_b;
        s1_y <= bus.in_y;
      end
      s2_v <= s1_v;
      if (s1_v) begin
        s2_ed  <= ed_c;
        s2_err <= |ed_c;
      end
      if (s2_v) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
        err_cnt    <= err_cnt + CNT_W'(s2_err);
        // sticky clamp once the carry out is seen
        ed_sum     <= sum_c[ACC_W] ? '1 : sum_c[ACC_W-1:0];
      end
    end
  end

`ifdef ERR_MAX_TRACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ed_max <= '0;
    end else if (start_ok) begin
      ed_max <= '0;
    end else if (s2_v && (s2_ed > ed_max)) begin
      ed_max <= s2_ed;
    end
  end
`else
  assign ed_max = '0;
`endif

endmodule

// File: tb/tb_mult_err_monitor.sv
// Directed bench for mult_err_monitor: three instances (N=256, N=4
// with 16-bit ED sum, N=8) exercising sweep, errors, bubbles, restart, reset.
module tb_mult_err_monitor;

`ifdef ERR_MAX_TRACK_EN
  localparam bit MAXT = 1'b1;
`else
  localparam bit MAXT = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic start_big, start4, start8;

  int checks = 0;
  int errors = 0;

  mult_err_monitor_if #(.OP_W(8)) bus_big ();
  mult_err_monitor_if #(.OP_W(8)) bus4 ();
  mult_err_monitor_if #(.OP_W(8)) bus8 ();

  logic        busy_b, done_b, busy4, done4, busy8, done8;
  logic [16:0] sc_b, ec_b, sc4, ec4, sc8, ec8;
  logic [39:0] sum_b, sum8;
  logic [15:0] sum4;
  logic [15:0] max_b, max4, max8;

  mult_err_monitor #(.N_SAMPLES(256)) u_big (
    .clk(clk), .rst_n(rst_n), .start(start_big), .bus(bus_big),
    .busy(busy_b), .done(done_b), .sample_cnt(sc_b), .err_cnt(ec_b),
    .ed_sum(sum_b), .ed_max(max_b)
  );

  mult_err_monitor #(.N_SAMPLES(4), .ACC_W(16)) u_n4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .bus(bus4),
    .busy(busy4), .done(done4), .sample_cnt(sc4), .err_cnt(ec4),
    .ed_sum(sum4), .ed_max(max4)
  );

  mult_err_monitor #(.N_SAMPLES(8)) u_n8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .bus(bus8),
    .busy(busy8), .done(done8), .sample_cnt(sc8), .err_cnt(ec8),
    .ed_sum(sum8), .ed_max(max8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mx(input logic [63:0] v);
    return MAXT ? v : 64'd0;
  endfunction

  task automatic drive_big(input int i, input logic [15:0] extra);
    bus_big.in_valid = 1'b1;
    bus_big.in_a = 8'(i);
    bus_big.in_b = 8'(255 - i);
    bus_big.in_y = ({8'd0, bus_big.in_a} * {8'd0, bus_big.in_b}) + extra;
  endtask

  task automatic drive4(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] y);
    bus4.in_valid = 1'b1;
    bus4.in_a = a;
    bus4.in_b = b;
    bus4.in_y = y;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    start_big = 0; start4 = 0; start8 = 0;
    bus_big.in_valid = 0; bus_big.in_a = 0; bus_big.in_b = 0; bus_big.in_y = 0;
    bus4.in_valid = 0; bus4.in_a = 0; bus4.in_b = 0; bus4.in_y = 0;
    bus8.in_valid = 0; bus8.in_a = 0; bus8.in_b = 0; bus8.in_y = 0;
    step();
    step();
    check("rst_busy", busy_b, 0);
    check("rst_done", done_b, 0);
    check("rst_ready", bus_big.in_ready, 0);
    check("rst_cnt", sc_b, 0);
    check("rst_sum", sum_b, 0);
    rst_n = 1'b1;
    step();

    // exact sweep
    start_big = 1; step(); start_big = 0;
    check("t1_busy", busy_b, 1);
    check("t1_ready", bus_big.in_ready, 1);
    for (int i = 0; i < 256; i++) begin
      drive_big(i, 16'd0);
      step();
    end
    bus_big.in_valid = 0;
    check("t1_ready_drop", bus_big.in_ready, 0);
    check("t1_done_t0", done_b, 0);
    step();
    check("t1_done_t1", done_b, 0);
    step();
    check("t1_done", done_b, 1);
    check("t1_busy_end", busy_b, 0);
    check("t1_samples", sc_b, 256);
    check("t1_errs", ec_b, 0);
    check("t1_sum", sum_b, 0);
    check("t1_max", max_b, 0);

    // every sample off by one
    start_big = 1; step(); start_big = 0;
    check("t2_clr_cnt", sc_b, 0);
    check("t2_busy", busy_b, 1);
    check("t2_done", done_b, 0);
    for (int i = 0; i < 256; i++) begin
      drive_big(i, 16'd1);
      step();
    end
    bus_big.in_valid = 0;
    step(); step();
    check("t2_errs", ec_b, 256);
    check("t2_sum", sum_b, 256);
    check("t2_max", max_b, mx(1));

    // start during RUN is ignored
    start_big = 1; step(); start_big = 0;
    for (int i = 0; i < 256; i++) begin
      drive_big(i, 16'd2);
      start_big = (i == 50);
      step();
    end
    start_big = 0;
    bus_big.in_valid = 0;
    step(); step();
    check("t5_done", done_b, 1);
    check("t5_samples", sc_b, 256);
    check("t5_errs", ec_b, 256);
    check("t5_sum", sum_b, 512);
    check("t5_max", max_b, mx(2));
    start_big = 1; step(); start_big = 0;
    check("t5_clr_cnt", sc_b, 0);
    check("t5_clr_err", ec_b, 0);
    check("t5_clr_sum", sum_b, 0);
    check("t5_clr_max", max_b, 0);
    check("t5_busy", busy_b, 1);

    // reset mid-run after 100 accepts
    for (int i = 0; i < 100; i++) begin
      drive_big(i, 16'd5);
      step();
    end
    bus_big.in_valid = 0;
    step(); step();
    check("t6_partial", sc_b, 100);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", busy_b, 0);
    check("t6_ready", bus_big.in_ready, 0);
    check("t6_cnt", sc_b, 0);
    check("t6_sum", sum_b, 0);
    check("t6_max", max_b, 0);
    step();
    rst_n = 1'b1;
    step();
    start_big = 1; step(); start_big = 0;
    for (int i = 0; i < 256; i++) begin
      drive_big(i, (i % 2 == 1) ? 16'd3 : 16'd0);
      step();
    end
    bus_big.in_valid = 0;
    step(); step();
    check("t6_done", done_b, 1);
    check("t6_samples", sc_b, 256);
    check("t6_errs", ec_b, 128);
    check("t6_sum2", sum_b, 384);
    check("t6_max2", max_b, mx(3));

    // N=4: one large error
    start4 = 1; step(); start4 = 0;
    drive4(8'd255, 8'd255, 16'd0);
    drive4(8'd1, 8'd2, 16'd2);
    drive4(8'd3, 8'd4, 16'd12);
    drive4(8'd10, 8'd10, 16'd100);
    bus4.in_valid = 0;
    step(); step();
    check("t3_done", done4, 1);
    check("t3_samples", sc4, 4);
    check("t3_errs", ec4, 1);
    check("t3_sum", sum4, 65025);
    check("t3_max", max4, mx(65025));

    // N=4, 16-bit sum: saturation
    start4 = 1; step(); start4 = 0;
    for (int i = 0; i < 4; i++) drive4(8'd255, 8'd255, 16'd0);
    bus4.in_valid = 0;
    step(); step();
    check("sat_errs", ec4, 4);
    check("sat_sum", sum4, 65535);
    check("sat_max", max4, mx(65025));

    // N=8 with bubbles between samples
    start8 = 1; step(); start8 = 0;
    for (int k = 0; k < 8; k++) begin
      bus8.in_valid = 1'b1;
      bus8.in_a = 8'(k);
      bus8.in_b = 8'(k);
      bus8.in_y = (k == 5) ? 16'd24 : 16'(k * k);
      step();
      if (k == 6) check("t4_ready_7", bus8.in_ready, 1);
      if (k == 7) check("t4_ready_8", bus8.in_ready, 0);
      bus8.in_valid = 1'b0;
      step();
    end
    check("t4_done_t1", done8, 0);
    step();
    check("t4_done_t2", done8, 1);
    check("t4_samples", sc8, 8);
    check("t4_errs", ec8, 1);
    check("t4_sum", sum8, 1);
    check("t4_max", max8, mx(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
